// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port block RAM with a one-cycle registered read between
//   two masters. Master 0 is the CPU memory interface and master 1 is the
//   host loader/debug port. At most one access is issued per cycle. Read data
//   is steered back to the master that issued the read. Master 1 can hold a
//   bounded lock for burst accesses.
//
// Ports
//   clk, rst              : clock; synchronous active-high reset
//   m0_req/we/addr/wdata  : CPU request. The request is held until it is granted.
//   m0_gnt                : CPU access is issued to the RAM this cycle
//   m0_rvalid/m0_rdata    : CPU read return. rdata is 0 when rvalid is low.
//   m1_*                  : loader port. Same meanings as the m0_* ports.
//   m1_lock               : with a granted m1_req, asks to keep the RAM next cycles
//   ram_we/addr/wdata     : RAM command. All fields are 0 when nothing is granted.
//   ram_rdata             : RAM registered read data
//   locked                : arbiter is in the LOCK state (mirrors the FSM state)
//
// Handshake: a master raises req and keeps req, we, addr and wdata stable
// until it sees gnt high in the same cycle. The access is issued in that
// cycle. For a read, rvalid is high exactly one cycle later, together with
// rdata.
module ram_port_arbiter #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int LOCK_MAX      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    input  logic                     m1_lock,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     locked
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    state_t     state_q, state_d;
    logic       last_q, last_d;        // most recently granted master
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       force_rel_q, force_rel_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_id_q, rd_id_d;

    logic       req0, req1;
    logic       gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            last_q      <= 1'b1;
            lock_cnt_q  <= 8'd0;
            force_rel_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_cnt_q  <= lock_cnt_d;
            force_rel_q <= force_rel_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
        end
    end

    always_comb begin
        // Masking the requests during reset keeps every command output quiet.
        req0        = m0_req && !rst;
        req1        = m1_req && !rst;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_d     = state_q;
        last_d      = last_q;
        lock_cnt_d  = lock_cnt_q;
        force_rel_d = force_rel_q;

        case (state_q)
            ST_ARB: begin
                if (force_rel_q) begin
                    gnt0 = req0;
                    gnt1 = req1 && !req0;
                end else if (req0 && req1) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
                // With force_rel set, m0 is either granted or idle in this
                // cycle. One ARB cycle is therefore always enough to clear it.
                force_rel_d = 1'b0;
                if (gnt1 && m1_lock && !force_rel_q) begin
                    if (LOCK_MAX_C <= 8'd1) begin
                        // The entry grant already uses up the whole budget.
                        force_rel_d = 1'b1;
                    end else begin
                        state_d    = ST_LOCK;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            ST_LOCK: begin
                gnt1 = req1;
                if (gnt1 && (lock_cnt_q < LOCK_MAX_C)) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
                if (gnt1 && (lock_cnt_d >= LOCK_MAX_C)) begin
                    state_d     = ST_ARB;
                    force_rel_d = 1'b1;
                    lock_cnt_d  = 8'd0;
                end else if (!m1_lock) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        if (gnt0) begin
            last_d = 1'b0;
        end
        if (gnt1) begin
            last_d = 1'b1;
        end

        rd_pend_d = (gnt0 && !m0_we) || (gnt1 && !m1_we);
        rd_id_d   = gnt1;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (gnt1) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rd_pend_q && !rd_id_q && !rst;
    assign m1_rvalid = rd_pend_q && rd_id_q && !rst;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;
    assign locked    = (state_q == ST_LOCK) && !rst;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 10;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we, locked;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;

  // clock / reset
  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .locked(locked)
  );

  // block RAM behind the arbiter: registered read, read-before-write
  logic [DW-1:0] ram_mem [0:63];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // reference memory contents, updated from expected grants only
  logic [DW-1:0] model_mem [0:63];

  typedef struct {
    logic          rst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          l1;
    logic          eg0, eg1, elk;
  } vec_t;

  // scoreboard: {id, data} of each expected read return
  logic [DW:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic rs, input logic r0, input logic w0,
                              input int a0, input int d0, input logic r1,
                              input logic w1, input int a1, input int d1,
                              input logic l1, input logic eg0, input logic eg1,
                              input logic elk);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = DW'(d1); v.l1 = l1;
    v.eg0 = eg0; v.eg1 = eg1; v.elk = elk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver + checker for one cycle
  task automatic apply_vec(input vec_t v, input string tag);
    logic [DW:0]   e;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    @(posedge clk);
    #1;
    rst = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.l1;
    @(negedge clk);
    x_we = 1'b0; x_addr = '0; x_wdata = '0;
    if (v.eg0) begin
      x_we = v.w0; x_addr = v.a0; x_wdata = v.d0;
    end else if (v.eg1) begin
      x_we = v.w1; x_addr = v.a1; x_wdata = v.d1;
    end
    check({tag, "_m0_gnt"}, 32'(m0_gnt), 32'(v.eg0));
    check({tag, "_m1_gnt"}, 32'(m1_gnt), 32'(v.eg1));
    check({tag, "_locked"}, 32'(locked), 32'(v.elk));
    check({tag, "_ram_we"}, 32'(ram_we), 32'(x_we));
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(x_addr));
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'(x_wdata));
    // a reset drops any read still in flight
    if (v.rst) exp_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'(!e[DW]));
      check({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'(e[DW]));
      check({tag, "_m0_rdata"}, 32'(m0_rdata), e[DW] ? 32'd0 : 32'(e[DW-1:0]));
      check({tag, "_m1_rdata"}, 32'(m1_rdata), e[DW] ? 32'(e[DW-1:0]) : 32'd0);
    end else begin
      check({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
      check({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
      check({tag, "_m0_rdata"}, 32'(m0_rdata), 32'd0);
      check({tag, "_m1_rdata"}, 32'(m1_rdata), 32'd0);
    end
    if (!v.rst) begin
      if (v.eg0) begin
        if (v.w0) model_mem[v.a0] = v.d0;
        else exp_q.push_back({1'b0, model_mem[v.a0]});
      end
      if (v.eg1) begin
        if (v.w1) model_mem[v.a1] = v.d1;
        else exp_q.push_back({1'b1, model_mem[v.a1]});
      end
    end
  endtask

  vec_t tbl [27];

  initial begin
    int rnd;
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = '0;
      model_mem[i] = '0;
    end
    ram_mem[50] = 10'd5;  model_mem[50] = 10'd5;
    ram_mem[51] = 10'd10; model_mem[51] = 10'd10;

    //              rst r0 w0 a0 d0  r1 w1 a1 d1 l1  eg0 eg1 elk
    tbl[0]  = mk(1, 1, 0, 50, 0,  1, 0, 51, 0,  0,  0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 50, 0,  1, 0, 51, 0,  0,  0, 0, 0);
    // contention after reset: m0 first, then alternate
    tbl[2]  = mk(0, 1, 0, 50, 0,  1, 0, 51, 0,  0,  1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 50, 0,  1, 0, 51, 0,  0,  0, 1, 0);
    tbl[4]  = mk(0, 1, 0, 50, 0,  1, 0, 51, 0,  0,  1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 50, 0,  1, 0, 51, 0,  0,  0, 1, 0);
    // m0 alone
    tbl[6]  = mk(0, 1, 0, 50, 0,  0, 0, 0,  0,  0,  1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,  0,  0, 0, 0,  0,  0,  0, 0, 0);
    // m1 locked writes of 50 to addr 52 while m0 waits
    tbl[8]  = mk(0, 1, 0, 50, 0,  1, 1, 52, 50, 1,  0, 1, 0);
    tbl[9]  = mk(0, 1, 0, 50, 0,  1, 1, 52, 50, 1,  0, 1, 1);
    tbl[10] = mk(0, 1, 0, 50, 0,  1, 1, 52, 50, 1,  0, 1, 1);
    tbl[11] = mk(0, 1, 0, 50, 0,  0, 0, 0,  0,  0,  0, 0, 1);
    tbl[12] = mk(0, 1, 0, 50, 0,  0, 0, 0,  0,  0,  1, 0, 0);
    // forced release after LOCK_MAX grants, then relock
    tbl[13] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  0, 1, 0);
    tbl[14] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  0, 1, 1);
    tbl[15] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  0, 1, 1);
    tbl[16] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  0, 1, 1);
    tbl[17] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  1, 0, 0);
    tbl[18] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  0, 1, 0);
    tbl[19] = mk(0, 1, 0, 52, 0,  1, 1, 53, 7,  1,  0, 1, 1);
    // read in flight while locked, then reset
    tbl[20] = mk(0, 1, 0, 52, 0,  1, 0, 51, 0,  1,  0, 1, 1);
    tbl[21] = mk(1, 1, 0, 52, 0,  1, 0, 51, 0,  1,  0, 0, 0);
    tbl[22] = mk(0, 1, 0, 50, 0,  1, 0, 51, 0,  0,  1, 0, 0);
    tbl[23] = mk(0, 1, 0, 50, 0,  1, 0, 51, 0,  0,  0, 1, 0);
    // write then read-after-write from the other master
    tbl[24] = mk(0, 1, 1, 52, 15, 0, 0, 0,  0,  0,  1, 0, 0);
    tbl[25] = mk(0, 0, 0, 0,  0,  1, 0, 52, 0,  0,  0, 1, 0);
    tbl[26] = mk(0, 0, 0, 0,  0,  0, 0, 0,  0,  0,  0, 0, 0);

    for (int i = 0; i < 27; i++) apply_vec(tbl[i], $sformatf("v%0d", i));

    // lock held across cycles where m1_req is low: no grant, m0 keeps waiting
    rnd = $urandom_range(1, 1023);
    apply_vec(mk(0, 0, 0, 0,  0, 1, 1, 54, rnd, 1, 0, 1, 0), "h1");
    apply_vec(mk(0, 1, 0, 54, 0, 0, 0, 0,  0,   1, 0, 0, 1), "h2");
    apply_vec(mk(0, 1, 0, 54, 0, 0, 0, 0,  0,   1, 0, 0, 1), "h3");
    apply_vec(mk(0, 1, 0, 54, 0, 1, 0, 54, 0,   0, 0, 1, 1), "h4");
    apply_vec(mk(0, 1, 0, 54, 0, 0, 0, 0,  0,   0, 1, 0, 0), "h5");
    apply_vec(mk(0, 0, 0, 0,  0, 0, 0, 0,  0,   0, 0, 0, 0), "h6");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
